imem_load_ctrl: RTL and testbench
=================================

IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 128, meaning instruction memory size in 32-bit words.
REQ-002 SHALL have parameter AW, default 7, meaning word-address width (log2 DEPTH).
REQ-003 SHALL have port CLK  input  1  the single clock; all state updates on rising edge.
REQ-004 SHALL have port RESET  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port PC  input  32  processor fetch byte address.
REQ-006 SHALL have port Instr  output  32  instruction delivered to the processor.
REQ-007 SHALL have port Stall  output  1  high when the processor must hold PC and not commit.
REQ-008 SHALL have port PcFault  output  1  fetch address outside memory.
REQ-009 SHALL have port LdStart  input  1  single-cycle request to begin a load session.
REQ-010 SHALL have port LdCount  input  8  words in the session, sampled with LdStart.
REQ-011 SHALL have port LdValid  input  1  loader word valid.
REQ-012 SHALL have port LdData  input  32  loader word.
REQ-013 SHALL have port LdReady  output  1  controller accepts a loader word this cycle.
REQ-014 SHALL have port MemWE  output  1  memory write enable.
REQ-015 SHALL have port MemAddr  output  AW  memory word address.
REQ-016 SHALL have port MemWD  output  32  memory write data.
REQ-017 SHALL have port MemRD  input  32  memory combinational read data at MemAddr.
REQ-018 SHALL have port WordsLoaded  output  8  words written in the current or last session.

Function
REQ-019 SHALL implement FSM states RUN, LOAD, FLUSH, held in a state register.
REQ-020 In RUN, SHALL drive MemAddr = PC[AW+1:2], MemWE = 0, Stall = 0, LdReady = 0, Instr = MemRD, with zero-cycle latency (combinational).
REQ-021 In RUN, when PC[31:AW+2] != 0, SHALL drive PcFault = 1 and Instr = 32'h0; otherwise PcFault = 0.
REQ-022 In RUN, LdStart with LdCount != 0 SHALL move to LOAD next cycle, clear the write pointer and WordsLoaded, and latch remaining = min(LdCount, DEPTH).
REQ-023 LdStart with LdCount == 0 SHALL be ignored (stay in RUN).
REQ-024 In LOAD, SHALL drive Stall = 1, LdReady = 1, Instr = 32'h0, PcFault = 0, MemAddr = write pointer, MemWD = LdData, MemWE = LdValid.
REQ-025 A transfer occurs when LdValid and LdReady are both high in a cycle; on each transfer, the pointer, WordsLoaded and remaining SHALL update by +1, +1 and -1 respectively at the clock edge.
REQ-026 LdValid low in LOAD SHALL cause no write and no state change (loader may insert gaps).
REQ-027 The transfer that takes remaining from 1 to 0 SHALL move to FLUSH; words offered after that SHALL not be accepted.
REQ-028 The pointer SHALL never exceed DEPTH-1; clamping in REQ-022 guarantees this, and no wrap-around write SHALL occur.
REQ-029 LdStart asserted in LOAD or FLUSH SHALL be ignored.
REQ-030 FLUSH SHALL last exactly one cycle with Stall = 1, LdReady = 0, MemWE = 0, Instr = 32'h0, then return to RUN.
REQ-031 WordsLoaded SHALL hold its value after the session until the next accepted LdStart or RESET.

Reset
REQ-032 RESET high SHALL asynchronously force state RUN, pointer 0, remaining 0, WordsLoaded 0.
REQ-033 During RESET, outputs SHALL be as in RUN: Stall 0, LdReady 0, MemWE 0.
REQ-034 RESET in mid-LOAD SHALL abort the session immediately; words already written remain in memory, and no write SHALL occur in the reset cycle.

Verification
REQ-035 Fetch: memory preloaded with word3 = E59F41EC, PC = 0x0C in RUN -> Instr = E59F41EC, Stall 0, PcFault 0 in the same cycle.
REQ-036 Fault: PC = 0x200 -> PcFault 1, Instr 0x0; PC = 0x1FC -> PcFault 0, Instr = word127.
REQ-037 Load with gaps: LdStart with LdCount = 3, then LdValid pattern 1,0,1,1 with data A,-,B,C -> words 0..2 = A,B,C; Stall high from the cycle after LdStart through FLUSH; RUN resumes 1 cycle after C; WordsLoaded = 3.
REQ-038 Clamp/ignore: LdCount = 200 -> exactly 128 writes then FLUSH; LdStart with LdCount = 0 -> no state change; second LdStart during LOAD -> ignored.
REQ-039 Reset mid-load: assert RESET after 2 of 5 words -> immediate RUN, Stall 0, WordsLoaded 0; words 0..1 retained, word 2 unchanged.

Source files
------------

// File: rtl/imem_load_ctrl.sv
// rtl/imem_load_ctrl.sv - instruction memory fetch path with a stalling word loader
// RUN serves fetches combinationally; LOAD streams loader words into memory; FLUSH is a one-cycle drain.
module imem_load_ctrl #(
   parameter int DEPTH = 128,
   parameter int AW    = 7
) (
   input  logic          CLK,
   input  logic          RESET,
   input  logic [31:0]   PC,
   output logic [31:0]   Instr,
   output logic          Stall,
   output logic          PcFault,
   input  logic          LdStart,
   input  logic [7:0]    LdCount,
   input  logic          LdValid,
   input  logic [31:0]   LdData,
   output logic          LdReady,
   output logic          MemWE,
   output logic [AW-1:0] MemAddr,
   output logic [31:0]   MemWD,
   input  logic [31:0]   MemRD,
   output logic [7:0]    WordsLoaded
);

   typedef enum logic [1:0] {S_RUN, S_LOAD, S_FLUSH} state_t;

   // Session length is clamped to the memory size so the pointer can never wrap into a live word.
   localparam int unsigned CAP  = (DEPTH > 255) ? 255 : DEPTH;
   localparam logic [7:0]  CAP8 = CAP[7:0];

   state_t        state_q, state_d;
   logic [AW-1:0] ptr_q, ptr_d;
   logic [7:0]    rem_q, rem_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          start_ok;
   logic          xfer;
   logic          fetch_fault;
   logic          pc_unused;

   assign pc_unused   = ^PC[1:0];
   assign start_ok    = (state_q == S_RUN) && LdStart && (LdCount != 8'd0);
   assign xfer        = (state_q == S_LOAD) && LdValid;
   assign fetch_fault = |PC[31:AW+2];
   assign WordsLoaded = cnt_q;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= S_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RUN:   if (start_ok) state_d = S_LOAD;
         S_LOAD:  if (xfer && (rem_q == 8'd1)) state_d = S_FLUSH;
         S_FLUSH: state_d = S_RUN;
         default: state_d = S_RUN;
      endcase
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         ptr_q <= '0;
         rem_q <= 8'd0;
         cnt_q <= 8'd0;
      end else begin
         ptr_q <= ptr_d;
         rem_q <= rem_d;
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      rem_d = rem_q;
      cnt_d = cnt_q;
      if (start_ok) begin
         ptr_d = '0;
         cnt_d = 8'd0;
         rem_d = (LdCount > CAP8) ? CAP8 : LdCount;
      end else if (xfer) begin
         ptr_d = ptr_q + AW'(1);
         cnt_d = cnt_q + 8'd1;
         rem_d = rem_q - 8'd1;
      end
   end

   always_comb begin
      MemAddr = PC[AW+1:2];
      MemWD   = LdData;
      MemWE   = 1'b0;
      Stall   = 1'b0;
      LdReady = 1'b0;
      PcFault = fetch_fault;
      Instr   = fetch_fault ? 32'h0 : MemRD;
      case (state_q)
         S_LOAD: begin
            MemAddr = ptr_q;
            MemWE   = LdValid;
            Stall   = 1'b1;
            LdReady = 1'b1;
            PcFault = 1'b0;
            Instr   = 32'h0;
         end
         S_FLUSH: begin
            MemAddr = ptr_q;
            Stall   = 1'b1;
            PcFault = 1'b0;
            Instr   = 32'h0;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_imem_load_ctrl.sv
// tb/tb_imem_load_ctrl.sv - directed self-checking bench for imem_load_ctrl
module tb_imem_load_ctrl;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic [31:0] PC = 32'h0;
   logic [31:0] Instr;
   logic        Stall;
   logic        PcFault;
   logic        LdStart = 1'b0;
   logic [7:0]  LdCount = 8'd0;
   logic        LdValid = 1'b0;
   logic [31:0] LdData = 32'h0;
   logic        LdReady;
   logic        MemWE;
   logic [6:0]  MemAddr;
   logic [31:0] MemWD;
   logic [31:0] MemRD;
   logic [7:0]  WordsLoaded;

   logic [31:0] mem [0:127];
   logic        pre_we = 1'b0;
   logic [6:0]  pre_addr = 7'd0;
   logic [31:0] pre_data = 32'h0;

   int n_cmp = 0;
   int n_err = 0;

   imem_load_ctrl #(.DEPTH(128), .AW(7)) dut (
      .CLK(CLK), .RESET(RESET), .PC(PC), .Instr(Instr), .Stall(Stall), .PcFault(PcFault),
      .LdStart(LdStart), .LdCount(LdCount), .LdValid(LdValid), .LdData(LdData), .LdReady(LdReady),
      .MemWE(MemWE), .MemAddr(MemAddr), .MemWD(MemWD), .MemRD(MemRD), .WordsLoaded(WordsLoaded)
   );

   always #5 CLK = ~CLK;

   assign MemRD = mem[MemAddr];

   always @(posedge CLK) begin
      if (pre_we) mem[pre_addr] <= pre_data;
      else if (MemWE) mem[MemAddr] <= MemWD;
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic preload(input logic [6:0] a, input logic [31:0] d);
      pre_we = 1'b1; pre_addr = a; pre_data = d;
      step();
      pre_we = 1'b0;
   endtask

   task automatic test_reset();
      preload(7'd0, 32'h11111111);
      preload(7'd3, 32'hE59F41EC);
      preload(7'd127, 32'h7F7F0127);
      #1;
      n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL rst_stall got %b want 0", Stall); end
      n_cmp++; if (LdReady !== 1'b0) begin n_err++; $display("FAIL rst_ldready got %b want 0", LdReady); end
      n_cmp++; if (MemWE !== 1'b0) begin n_err++; $display("FAIL rst_memwe got %b want 0", MemWE); end
      n_cmp++; if (WordsLoaded !== 8'd0) begin n_err++; $display("FAIL rst_words got %0d want 0", WordsLoaded); end
      RESET = 1'b0;
      step();
   endtask

   task automatic test_fetch();
      PC = 32'h0000000C;
      #1;
      n_cmp++; if (Instr !== 32'hE59F41EC) begin n_err++; $display("FAIL fetch_instr got %h want E59F41EC", Instr); end
      n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL fetch_stall got %b want 0", Stall); end
      n_cmp++; if (PcFault !== 1'b0) begin n_err++; $display("FAIL fetch_fault got %b want 0", PcFault); end
      n_cmp++; if (MemAddr !== 7'd3) begin n_err++; $display("FAIL fetch_addr got %0d want 3", MemAddr); end
   endtask

   task automatic test_fault();
      PC = 32'h00000200;
      #1;
      n_cmp++; if (PcFault !== 1'b1) begin n_err++; $display("FAIL fault_hi got %b want 1", PcFault); end
      n_cmp++; if (Instr !== 32'h0) begin n_err++; $display("FAIL fault_instr got %h want 0", Instr); end
      PC = 32'h000001FC;
      #1;
      n_cmp++; if (PcFault !== 1'b0) begin n_err++; $display("FAIL edge_fault got %b want 0", PcFault); end
      n_cmp++; if (Instr !== 32'h7F7F0127) begin n_err++; $display("FAIL edge_instr got %h want 7F7F0127", Instr); end
      PC = 32'h0;
   endtask

   task automatic test_load_gaps();
      LdStart = 1'b1; LdCount = 8'd3;
      #1;
      n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL gap_pre_stall got %b want 0", Stall); end
      step();
      LdStart = 1'b0; LdValid = 1'b1; LdData = 32'hA0A0A0A0;
      #1;
      n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL gap_load_stall got %b want 1", Stall); end
      n_cmp++; if (LdReady !== 1'b1) begin n_err++; $display("FAIL gap_ldready got %b want 1", LdReady); end
      n_cmp++; if (MemWE !== 1'b1) begin n_err++; $display("FAIL gap_memwe got %b want 1", MemWE); end
      n_cmp++; if (Instr !== 32'h0) begin n_err++; $display("FAIL gap_instr got %h want 0", Instr); end
      n_cmp++; if (WordsLoaded !== 8'd0) begin n_err++; $display("FAIL gap_words0 got %0d want 0", WordsLoaded); end
      step();
      LdValid = 1'b0;
      #1;
      n_cmp++; if (MemWE !== 1'b0) begin n_err++; $display("FAIL gap_idle_we got %b want 0", MemWE); end
      n_cmp++; if (WordsLoaded !== 8'd1) begin n_err++; $display("FAIL gap_words1 got %0d want 1", WordsLoaded); end
      step();
      LdValid = 1'b1; LdData = 32'hB0B0B0B0;
      #1;
      n_cmp++; if (MemAddr !== 7'd1) begin n_err++; $display("FAIL gap_addr1 got %0d want 1", MemAddr); end
      step();
      LdData = 32'hC0C0C0C0;
      #1;
      n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL gap_stall_c got %b want 1", Stall); end
      step();
      LdData = 32'hD0D0D0D0;
      #1;
      n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("FAIL flush_stall got %b want 1", Stall); end
      n_cmp++; if (LdReady !== 1'b0) begin n_err++; $display("FAIL flush_ldready got %b want 0", LdReady); end
      n_cmp++; if (MemWE !== 1'b0) begin n_err++; $display("FAIL flush_memwe got %b want 0", MemWE); end
      step();
      LdValid = 1'b0;
      #1;
      n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL gap_run_stall got %b want 0", Stall); end
      n_cmp++; if (WordsLoaded !== 8'd3) begin n_err++; $display("FAIL gap_words3 got %0d want 3", WordsLoaded); end
      n_cmp++; if (Instr !== 32'hA0A0A0A0) begin n_err++; $display("FAIL gap_fetch0 got %h want A0A0A0A0", Instr); end
      n_cmp++; if (mem[1] !== 32'hB0B0B0B0) begin n_err++; $display("FAIL gap_mem1 got %h want B0B0B0B0", mem[1]); end
      n_cmp++; if (mem[2] !== 32'hC0C0C0C0) begin n_err++; $display("FAIL gap_mem2 got %h want C0C0C0C0", mem[2]); end
      n_cmp++; if (mem[3] !== 32'hE59F41EC) begin n_err++; $display("FAIL gap_mem3 got %h want E59F41EC", mem[3]); end
   endtask

   task automatic test_zero_count();
      LdStart = 1'b1; LdCount = 8'd0;
      step();
      LdStart = 1'b0;
      #1;
      n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL zero_stall got %b want 0", Stall); end
      n_cmp++; if (WordsLoaded !== 8'd3) begin n_err++; $display("FAIL zero_words got %0d want 3", WordsLoaded); end
   endtask

   task automatic test_clamp();
      int writes = 0;
      bit flushed = 0;
      LdStart = 1'b1; LdCount = 8'd200;
      step();
      LdStart = 1'b0; LdValid = 1'b1;
      for (int i = 0; i < 300 && !flushed; i++) begin
         LdData = 32'h1000 + writes;
         LdStart = (i == 10);
         LdCount = 8'd5;
         #1;
         if (Stall && !LdReady) flushed = 1;
         else begin
            if (LdReady && LdValid) writes++;
            step();
         end
      end
      LdValid = 1'b0; LdStart = 1'b0;
      n_cmp++; if (!flushed) begin n_err++; $display("FAIL clamp_flush got none want FLUSH within 300 cycles"); end
      n_cmp++; if (writes !== 128) begin n_err++; $display("FAIL clamp_writes got %0d want 128", writes); end
      n_cmp++; if (WordsLoaded !== 8'd128) begin n_err++; $display("FAIL clamp_words got %0d want 128", WordsLoaded); end
      step();
      n_cmp++; if (mem[127] !== 32'h107F) begin n_err++; $display("FAIL clamp_mem127 got %h want 107F", mem[127]); end
      n_cmp++; if (mem[0] !== 32'h1000) begin n_err++; $display("FAIL clamp_mem0 got %h want 1000", mem[0]); end
      n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL clamp_run got %b want 0", Stall); end
   endtask

   task automatic test_reset_midload();
      LdStart = 1'b1; LdCount = 8'd5;
      step();
      LdStart = 1'b0; LdValid = 1'b1; LdData = 32'hAAAA0000;
      step();
      LdData = 32'hAAAA0001;
      step();
      LdData = 32'hAAAA0002;
      RESET = 1'b1;
      #1;
      n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("FAIL mid_stall got %b want 0", Stall); end
      n_cmp++; if (WordsLoaded !== 8'd0) begin n_err++; $display("FAIL mid_words got %0d want 0", WordsLoaded); end
      n_cmp++; if (MemWE !== 1'b0) begin n_err++; $display("FAIL mid_memwe got %b want 0", MemWE); end
      step();
      RESET = 1'b0; LdValid = 1'b0;
      step();
      n_cmp++; if (mem[0] !== 32'hAAAA0000) begin n_err++; $display("FAIL mid_mem0 got %h want AAAA0000", mem[0]); end
      n_cmp++; if (mem[1] !== 32'hAAAA0001) begin n_err++; $display("FAIL mid_mem1 got %h want AAAA0001", mem[1]); end
      n_cmp++; if (mem[2] !== 32'h1002) begin n_err++; $display("FAIL mid_mem2 got %h want 1002", mem[2]); end
   endtask

   initial begin
      test_reset();
      test_fetch();
      test_fault();
      test_load_gaps();
      test_zero_count();
      test_clamp();
      test_reset_midload();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
